// File: rtl/weight_fifo.sv
// weight_fifo: circular row buffer between the off-chip weight loader and the
// control unit / systolic array weight path. One row is ROW_BYTES weights of
// DATA_W bits. Reads have one cycle of latency, and valid_o marks each popped
// row. All status outputs are registered, so no input reaches an output
// combinationally.
module weight_fifo #(
    parameter int ROW_BYTES = 32,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int TILE_ROWS = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [ROW_BYTES*DATA_W-1:0]  wr_data_i,
    output logic                         full_o,
    input  logic                         rd_en_i,
    output logic [ROW_BYTES*DATA_W-1:0]  rd_data_o,
    output logic                         valid_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         tile_rdy_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int ROW_W = ROW_BYTES * DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ROW_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [ROW_W-1:0] r_rdData;
    logic             r_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_tileRdy;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_pushOk;
    logic             w_popOk;
    logic [CNT_W-1:0] w_countNext;

    // A flush in the same cycle cancels any push or pop. Requests are
    // qualified against the registered full/empty flags.
    assign w_pushOk = wr_en_i && !r_full  && !flush_i;
    assign w_popOk  = rd_en_i && !r_empty && !flush_i;

    // Work out the row count after this edge. The status flags are taken from
    // this value, so they always agree with count_o.
    always_comb begin
        w_countNext = r_count;
        if (flush_i) begin
            w_countNext = '0;
        end else begin
            case ({w_pushOk, w_popOk})
                2'b10:   w_countNext = r_count + CNT_W'(1);
                2'b01:   w_countNext = r_count - CNT_W'(1);
                default: w_countNext = r_count;
            endcase
        end
    end

    // The storage array has no reset. Stale rows cannot be read back because
    // the pointers and the count are reset.
    always_ff @(posedge clk_i) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= wr_data_i;
        end
    end

    // Update the pointers, the registered read data, the status flags and the
    // sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_rdData    <= '0;
            r_valid     <= 1'b0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_tileRdy   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count   <= w_countNext;
            r_full    <= (w_countNext == CNT_W'(DEPTH));
            r_empty   <= (w_countNext == '0);
            r_tileRdy <= (w_countNext >= CNT_W'(TILE_ROWS));
            r_valid   <= w_popOk;
            if (flush_i) begin
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_pushOk) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_popOk) begin
                    r_rdPtr  <= r_rdPtr + PTR_W'(1);
                    r_rdData <= r_mem[r_rdPtr];
                end
                if (wr_en_i && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (rd_en_i && r_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign rd_data_o   = r_rdData;
    assign valid_o     = r_valid;
    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign count_o     = r_count;
    assign tile_rdy_o  = r_tileRdy;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_weight_fifo.sv
// tb_weight_fifo: self-checking bench for weight_fifo. A behavioural queue
// model tracks the stored rows. Each accepted pop moves the expected row into
// a scoreboard queue, and that row is compared against rd_data_o one cycle
// later.
module tb_weight_fifo;

    localparam int ROW_BYTES = 32;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 64;
    localparam int TILE_ROWS = 32;
    localparam int ROW_W     = ROW_BYTES * DATA_W;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [ROW_W-1:0] wr_data_i = '0;
    logic             rd_en_i = 1'b0;
    logic             full_o;
    logic [ROW_W-1:0] rd_data_o;
    logic             valid_o;
    logic             empty_o;
    logic [CNT_W-1:0] count_o;
    logic             tile_rdy_o;
    logic             overflow_o;
    logic             underflow_o;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [ROW_W-1:0] modelQ[$];
    logic [ROW_W-1:0] scoreQ[$];
    logic             modelOvf  = 1'b0;
    logic             modelUnf  = 1'b0;
    logic [ROW_W-1:0] modelLast = '0;

    weight_fifo #(
        .ROW_BYTES (ROW_BYTES),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .TILE_ROWS (TILE_ROWS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .full_o      (full_o),
        .rd_en_i     (rd_en_i),
        .rd_data_o   (rd_data_o),
        .valid_o     (valid_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .tile_rdy_o  (tile_rdy_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk_i = ~clk_i;

    // Stop the run if it goes far beyond the expected length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                               input logic [ROW_W-1:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h required=%0h", tag, observed, expected);
        end
    endtask

    // Build a row with an index in byte 0 and random contents elsewhere.
    function automatic logic [ROW_W-1:0] makeRow(input int idx);
        logic [ROW_W-1:0] row;
        for (int b = 0; b < ROW_W / 32; b++) begin
            row[b*32 +: 32] = $urandom;
        end
        row[7:0] = idx[7:0];
        return row;
    endfunction

    // Drive one cycle of requests, advance the model, then check every output.
    task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                                 input logic [ROW_W-1:0] data);
        logic             pushOk;
        logic             popOk;
        logic [ROW_W-1:0] expRow;
        wr_en_i   = wr;
        rd_en_i   = rd;
        flush_i   = fl;
        wr_data_i = data;
        pushOk = wr && !fl && (modelQ.size() < DEPTH);
        popOk  = rd && !fl && (modelQ.size() > 0);
        if (fl) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            if (wr && modelQ.size() == DEPTH) modelOvf = 1'b1;
            if (rd && modelQ.size() == 0)     modelUnf = 1'b1;
            if (popOk)  scoreQ.push_back(modelQ.pop_front());
            if (pushOk) modelQ.push_back(data);
        end
        @(posedge clk_i);
        #1;
        checkOutput("valid", ROW_W'(valid_o), ROW_W'(popOk));
        if (popOk && scoreQ.size() > 0) begin
            expRow = scoreQ.pop_front();
            modelLast = expRow;
            checkOutput("rdData", rd_data_o, expRow);
        end else begin
            checkOutput("rdHold", rd_data_o, modelLast);
        end
        checkOutput("count", ROW_W'(count_o), ROW_W'(modelQ.size()));
        checkOutput("empty", ROW_W'(empty_o), ROW_W'(modelQ.size() == 0));
        checkOutput("full", ROW_W'(full_o), ROW_W'(modelQ.size() == DEPTH));
        checkOutput("tileRdy", ROW_W'(tile_rdy_o), ROW_W'(modelQ.size() >= TILE_ROWS));
        checkOutput("overflow", ROW_W'(overflow_o), ROW_W'(modelOvf));
        checkOutput("underflow", ROW_W'(underflow_o), ROW_W'(modelUnf));
    endtask

    // Main sequence: reset, tile fill/drain, full and wrap, empty corner,
    // steady state, flush, asynchronous reset.
    initial begin
        #12;
        checkOutput("rstCount", ROW_W'(count_o), '0);
        checkOutput("rstEmpty", ROW_W'(empty_o), ROW_W'(1));
        checkOutput("rstValid", ROW_W'(valid_o), '0);
        checkOutput("rstData", rd_data_o, '0);
        checkOutput("rstTile", ROW_W'(tile_rdy_o), '0);
        rst_i = 1'b0;
        #4;

        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 1'b0, makeRow(i));
        checkOutput("tileAt32", ROW_W'(tile_rdy_o), ROW_W'(1));
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("emptyAfterDrain", ROW_W'(empty_o), ROW_W'(1));

        for (int i = 0; i < 65; i++) applyStimulus(1'b1, 1'b0, 1'b0, makeRow(i));
        checkOutput("countCapped", ROW_W'(count_o), ROW_W'(DEPTH));
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        applyStimulus(1'b1, 1'b1, 1'b0, makeRow(200));
        checkOutput("emptyPushPop", ROW_W'(count_o), ROW_W'(1));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, makeRow(i));
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, 1'b0, makeRow(10 + i));
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0, makeRow(i));
        checkOutput("count40", ROW_W'(count_o), ROW_W'(40));
        applyStimulus(1'b1, 1'b1, 1'b1, makeRow(99));
        checkOutput("flushCount", ROW_W'(count_o), '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, makeRow(i));
        applyStimulus(1'b1, 1'b1, 1'b0, makeRow(5));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("asyncCount", ROW_W'(count_o), '0);
        checkOutput("asyncEmpty", ROW_W'(empty_o), ROW_W'(1));
        checkOutput("asyncValid", ROW_W'(valid_o), '0);
        checkOutput("asyncData", rd_data_o, '0);
        checkOutput("asyncOvf", ROW_W'(overflow_o | underflow_o), '0);
        modelQ.delete();
        scoreQ.delete();
        modelOvf  = 1'b0;
        modelUnf  = 1'b0;
        modelLast = '0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        #3;
        rst_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, makeRow(7));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
